// File: rtl/interrupt_controller_pkg.sv
// Shared definitions for the interrupt controller: FSM state encoding and the
// default handler vector base.
package interrupt_controller_pkg;

  typedef logic [1:0] irq_state_t;

  localparam irq_state_t ST_IDLE   = 2'd0;
  localparam irq_state_t ST_ENTER  = 2'd1;
  localparam irq_state_t ST_ACTIVE = 2'd2;

  localparam logic [31:0] VEC_BASE_DEFAULT = 32'h0000_0100;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder: returns the id of the lowest set
// request bit and whether any bit is set.
module irq_prio_enc #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req_i,
  output logic [ID_W-1:0] id_o,
  output logic            valid_o
);

  // Scanning downward lets the lowest set bit win by being written last.
  always_comb begin
    id_o    = '0;
    valid_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        id_o    = ID_W'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Single-level interrupt controller: edge-captured pending bits, enable mask,
// and a take/handler FSM that hands the pipeline a vector and a return PC.
//   state  | meaning
//   IDLE   | no handler running; take when an enabled source is pending
//   ENTER  | one-cycle take pulse on interrupt
//   ACTIVE | handler running; waits for mret_E
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter int          N_IRQ    = 4,
  parameter logic [31:0] VEC_BASE = VEC_BASE_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_IRQ-1:0]           irq_src,
  input  logic                       irq_en_we,
  input  logic [N_IRQ-1:0]           irq_en_wdata,
  input  logic                       PCSrc_E,
  input  logic                       Stall_D,
  input  logic                       mret_E,
  input  logic [31:0]                PC_E,
  output logic                       interrupt,
  output logic [31:0]                irq_vector,
  output logic [$clog2(N_IRQ)-1:0]   irq_id,
  output logic [31:0]                mepc,
  output logic                       irq_active,
  output logic [N_IRQ-1:0]           irq_pending
);

  localparam int ID_W = $clog2(N_IRQ);

  irq_state_t       state_q, state_d;
  logic [N_IRQ-1:0] src_q;
  logic [N_IRQ-1:0] pend_q, pend_d;
  logic [N_IRQ-1:0] en_q, en_d;
  logic [N_IRQ-1:0] clr_mask;
  logic [N_IRQ-1:0] eligible;
  logic [ID_W-1:0]  id_q, id_d, enc_id;
  logic [31:0]      mepc_q, mepc_d;
  logic             enc_valid;
  logic             take;

  assign eligible = pend_q & en_q;

  irq_prio_enc #(
    .N    (N_IRQ),
    .ID_W (ID_W)
  ) u_prio_enc (
    .req_i   (eligible),
    .id_o    (enc_id),
    .valid_o (enc_valid)
  );

  // A blocked take is simply re-evaluated next cycle, so nothing is lost.
  assign take = (state_q == ST_IDLE) & enc_valid & ~PCSrc_E & ~Stall_D & ~mret_E;

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    mepc_d   = mepc_q;
    clr_mask = '0;
    case (state_q)
      ST_IDLE: begin
        if (take) begin
          state_d  = ST_ENTER;
          id_d     = enc_id;
          mepc_d   = PC_E;
          clr_mask = N_IRQ'(1) << enc_id;
        end
      end
      ST_ENTER:  state_d = ST_ACTIVE;
      ST_ACTIVE: if (mret_E) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Edges are OR-ed in after the clear so a same-cycle edge re-arms the bit.
  assign pend_d = (pend_q & ~clr_mask) | (irq_src & ~src_q);
  assign en_d   = irq_en_we ? irq_en_wdata : en_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      pend_q  <= '0;
      en_q    <= '0;
      id_q    <= '0;
      mepc_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= irq_src;
      pend_q  <= pend_d;
      en_q    <= en_d;
      id_q    <= id_d;
      mepc_q  <= mepc_d;
    end
  end

  assign interrupt   = (state_q == ST_ENTER) & ~rst;
  assign irq_active  = (state_q != ST_IDLE) & ~rst;
  assign irq_vector  = VEC_BASE + (32'(id_q) << 2);
  assign irq_id      = id_q;
  assign mepc        = mepc_q;
  assign irq_pending = pend_q;

endmodule

// File: doc/interrupt_controller.md
INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 SHALL have parameter N_IRQ, default 4, number of interrupt sources (2..8).
REQ-002 SHALL have parameter VEC_BASE, default 32'h0000_0100, handler vector base address.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port irq_src, input, N_IRQ, asynchronous-free (already synchronised) source levels.
REQ-006 SHALL have port irq_en_we, input, 1, write strobe for the enable mask.
REQ-007 SHALL have port irq_en_wdata, input, N_IRQ, new enable mask.
REQ-008 SHALL have port PCSrc_E, input, 1, branch/jump taken in Execute.
REQ-009 SHALL have port Stall_D, input, 1, load-use stall active.
REQ-010 SHALL have port mret_E, input, 1, return-from-interrupt in Execute.
REQ-011 SHALL have port PC_E, input, 32, PC of instruction in Execute.
REQ-012 SHALL have port interrupt, output, 1, one-cycle take pulse to the hazard unit and PC mux.
REQ-013 SHALL have port irq_vector, output, 32, handler address.
REQ-014 SHALL have port irq_id, output, clog2(N_IRQ), id of the taken source.
REQ-015 SHALL have port mepc, output, 32, saved return PC.
REQ-016 SHALL have port irq_active, output, 1, handler in progress.
REQ-017 SHALL have port irq_pending, output, N_IRQ, pending bits.

Function
REQ-018 SHALL register irq_src each cycle into irq_src_q; a bit's rising edge is irq_src & ~irq_src_q.
REQ-019 SHALL set a pending bit on its rising edge regardless of the enable mask.
REQ-020 SHALL load the enable mask from irq_en_wdata when irq_en_we is high, effective the next cycle.
REQ-021 SHALL implement an FSM with states IDLE, ENTER and ACTIVE.
REQ-022 SHALL, in IDLE, take when |(pending & enable) & ~PCSrc_E & ~Stall_D & ~mret_E is true.
REQ-023 SHALL, on take: select the lowest-index eligible bit, latch it into irq_id, latch mepc <= PC_E, clear that pending bit, and go to ENTER.
REQ-024 SHALL assert interrupt only in ENTER, for exactly one cycle, then go to ACTIVE.
REQ-025 SHALL drive irq_vector = VEC_BASE + (irq_id << 2) at all times.
REQ-026 SHALL hold irq_active high in ENTER and ACTIVE.
REQ-027 SHALL block nested takes in ENTER and ACTIVE, while edges still set pending bits.
REQ-028 SHALL, in ACTIVE, go to IDLE on mret_E; mepc and irq_id hold their values.
REQ-029 SHALL, if an edge and the take-clear hit the same pending bit in one cycle, leave the bit set.
REQ-030 SHALL treat a take condition blocked by PCSrc_E or Stall_D as deferred, not lost; it is re-evaluated every cycle.
REQ-031 SHALL, from IDLE, allow a new take no earlier than the cycle after the return to IDLE.

Reset
REQ-032 SHALL, on rst, set state=IDLE, pending=0, enable=0, irq_src_q=0, irq_id=0, mepc=0.
REQ-033 SHALL, on rst, drive interrupt=0 and irq_active=0; irq_vector=VEC_BASE.
REQ-034 SHALL let reset mid-ENTER/ACTIVE abort without an interrupt pulse in the following cycle.
REQ-035 SHALL treat a source already high at reset release as a rising edge, because irq_src_q is 0.

Structure
REQ-036 SHALL place the FSM state encoding and the VEC_BASE default in the shared pipeline package.
REQ-037 SHALL contain one sub-module, irq_prio_enc, a combinational lowest-index-first priority encoder (N_IRQ -> id plus valid).

Verification
REQ-038 SHALL cover: enable=4'b0011, irq_src[1] rises, PC_E=0x40 -> interrupt pulses 1 cycle 2 cycles later, irq_id=1, irq_vector=0x104, mepc=0x40.
REQ-039 SHALL cover: irq_src[0] and irq_src[2] rise together, enable=4'b1111 -> id 0 taken; after mret_E, id 2 taken with vector 0x108.
REQ-040 SHALL cover: pending & enable nonzero with PCSrc_E=1 for 1 cycle and Stall_D=1 for 2 cycles -> take delayed until both are low, and not lost.
REQ-041 SHALL cover: edge on bit 3 with enable=0 -> pending[3]=1 and no interrupt; write enable=4'b1000 -> take next eligible cycle, id=3.
REQ-042 SHALL cover: irq_src[2] rises while ACTIVE -> no pulse until mret_E, then a single take of id 2.
REQ-043 SHALL cover: rst asserted in ENTER -> interrupt=0 next cycle, irq_active=0, pending=0.
